icache_refill_ctrl: RTL
=======================

// Module: icache_refill_ctrl
// PURPOSE
// Miss/refill controller for the instruction cache in the fetch unit. It detects a miss and
// latches the block-aligned miss address. It then requests the block from IRAM, assembles the
// returned beats into one cache block, and pulses the cache write enable for exactly one cycle.
// Fetch is stalled for the whole refill. A flush (branch redirect) aborts a refill cleanly.
// PARAMETERS
// PC_SIZE     32   width of program counter / IRAM address
// BLOCK_SIZE  128  cache block width in bits (matches i-cache block_in)
// BEAT_SIZE   32   IRAM data beat width in bits; BLOCK_SIZE % BEAT_SIZE == 0
// PORTS
// clk         in   1                  clock, all state updates on rising edge
// nrst        in   1                  reset, synchronous, active on logic 1'b0
// fetch_req   in   1                  fetch unit presents a valid pc this cycle
// pc          in   PC_SIZE            fetch program counter
// hit         in   1                  i-cache hit for pc (combinational from cache)
// flush       in   1                  redirect: abandon current refill
// stall       out  1                  fetch must hold pc
// mem_req     out  1                  IRAM block read request
// mem_addr    out  PC_SIZE            block-aligned IRAM address
// mem_gnt     in   1                  IRAM accepts request (mem_req & mem_gnt = handshake)
// mem_valid   in   1                  one data beat valid on mem_data
// mem_data    in   BEAT_SIZE          IRAM data beat
// cache_we    out  1                  write enable to i-cache
// block_out   out  [0:BLOCK_SIZE-1]   assembled block to i-cache block_in
// BEHAVIOUR
// - NBEATS = BLOCK_SIZE/BEAT_SIZE; OFF = $clog2(BLOCK_SIZE/8); beat counter width $clog2(NBEATS)+1.
// - Reset (nrst=0 at clk edge): state=IDLE, mem_req=0, mem_addr=0, cache_we=0, block_out=0,
//   beat cnt=0, drop flag=0. stall=0 after reset. Reset mid-refill discards everything; later
//   IRAM beats are ignored in IDLE.
// - IDLE: stall = fetch_req & ~hit & ~flush (combinational). On that condition, latch
//   mem_addr={pc[PC_SIZE-1:OFF],OFF'b0} and go REQ. A miss with flush=1 is ignored.
// - REQ: mem_req=1, stall=1. mem_req & mem_addr stay stable until mem_gnt.
//   mem_gnt=1 -> FILL, cnt=0. flush=1 & mem_gnt=0 -> IDLE, no IRAM transaction.
//   flush=1 & mem_gnt=1 same cycle -> FILL with drop=1.
// - FILL: mem_req=0, stall=1. Each mem_valid writes mem_data into block_out[cnt*BEAT_SIZE +: BEAT_SIZE]
//   (ascending index, beat 0 at bit 0) and increments cnt. After beat NBEATS-1: drop=0 -> WRITE;
//   drop=1 -> IDLE. flush in FILL sets drop=1; beats are still drained, never written.
// - WRITE: cache_we=1 for exactly one cycle with block_out stable; stall=1; -> IDLE. flush in WRITE
//   is ignored (block is valid, write completes). mem_valid outside FILL is ignored.
// - Write-to-cache address comes from pc. Fetch holds pc through the refill, so the tag/set
//   written match the miss. On a drop, stall deasserts in IDLE and fetch presents the new pc.
// - Latency, miss detected in cycle 0, immediate gnt, NBEATS back-to-back beats starting cycle 2:
//   cache_we in cycle 2+NBEATS, hit visible in cycle 3+NBEATS.
// - At most one outstanding refill; no new miss is accepted outside IDLE.
// - Assertions: cache_we one-hot in time per refill; mem_req never high outside REQ;
//   cnt never exceeds NBEATS.
// TESTING
// 1 Reset: nrst=0 two cycles with fetch_req=1,hit=0 -> stall=0, mem_req=0, cache_we=0, block_out=0.
// 2 Basic miss: pc=0x0000_1234, hit=0, gnt same cycle, beats 0x11111111,0x22222222,0x33333333,
//   0x44444444 -> mem_addr=0x0000_1230; cache_we one cycle with
//   block_out=0x11111111_22222222_33333333_44444444; stall low the cycle after hit rises.
// 3 Slow grant: mem_gnt held low 5 cycles -> mem_req=1 and mem_addr stable for all 6 cycles,
//   stall=1 throughout.
// 4 Flush in REQ before gnt -> IDLE next cycle, no cache_we, no further mem_req.
// 5 Flush after second beat in FILL -> remaining 2 beats consumed, cache_we never asserted,
//   stall drops after the last beat.
// 6 Gapped beats (mem_valid 1,0,0,1,0,1,1) and a stray mem_valid in IDLE -> same block as test 2,
//   stray beat ignored.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Fetch/cache/IRAM signal bundle for the i-cache refill controller.
// master = refill controller side, slave = fetch unit, cache and IRAM side.
interface icache_refill_ctrl_if #(
  parameter int PC_SIZE    = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int BEAT_SIZE  = 32
);
  logic                  fetch_req;
  logic [PC_SIZE-1:0]    pc;
  logic                  hit;
  logic                  flush;
  logic                  stall;
  logic                  mem_req;
  logic [PC_SIZE-1:0]    mem_addr;
  logic                  mem_gnt;
  logic                  mem_valid;
  logic [BEAT_SIZE-1:0]  mem_data;
  logic                  cache_we;
  logic [0:BLOCK_SIZE-1] block_out;

  modport master (
    input  fetch_req, pc, hit, flush, mem_gnt, mem_valid, mem_data,
    output stall, mem_req, mem_addr, cache_we, block_out
  );

  modport slave (
    output fetch_req, pc, hit, flush, mem_gnt, mem_valid, mem_data,
    input  stall, mem_req, mem_addr, cache_we, block_out
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill FSM: latch block address, fetch NBEATS beats from IRAM, pulse cache_we once.
// Latency 2+NBEATS cycles miss-to-write with immediate grant; fetch stalled throughout, flush drops the refill.
module icache_refill_ctrl #(
  parameter int PC_SIZE    = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int BEAT_SIZE  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  icache_refill_ctrl_if.master bus
);
  localparam int NBEATS = BLOCK_SIZE / BEAT_SIZE;
  localparam int OFF    = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_W  = $clog2(NBEATS) + 1;
  localparam int BIX_W  = $clog2(BLOCK_SIZE);
  localparam int BSH    = $clog2(BEAT_SIZE);

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic [PC_SIZE-1:0]    r_mem_addr;
  logic                  r_cache_we;
  logic [0:BLOCK_SIZE-1] r_block_out;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_drop;

  logic                  w_miss;
  logic                  w_last;
  logic [BIX_W-1:0]      w_base;
  logic                  w_unused_pc;

  // Gated by reset so fetch is never stalled while the controller is held in reset.
  assign w_miss      = i_nrst & bus.fetch_req & ~bus.hit & ~bus.flush;
  assign w_last      = (r_cnt == CNT_W'(NBEATS - 1));
  assign w_base      = {r_cnt[CNT_W-2:0], {BSH{1'b0}}};
  assign w_unused_pc = ^bus.pc[OFF-1:0];

  assign bus.stall     = (r_state != IDLE) | w_miss;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.cache_we  = r_cache_we;
  assign bus.block_out = r_block_out;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_cache_we  <= 1'b0;
      r_block_out <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_cache_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_mem_addr <= {bus.pc[PC_SIZE-1:OFF], {OFF{1'b0}}};
            r_mem_req  <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            // A flush coinciding with the grant still owes IRAM the beats.
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_drop    <= bus.flush;
            r_state   <= FILL;
          end else if (bus.flush) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        FILL: begin
          if (bus.flush) r_drop <= 1'b1;
          if (bus.mem_valid) begin
            r_block_out[w_base +: BEAT_SIZE] <= bus.mem_data;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              if (r_drop | bus.flush) begin
                r_drop  <= 1'b0;
                r_state <= IDLE;
              end else begin
                r_cache_we <= 1'b1;
                r_state    <= WRITE;
              end
            end
          end
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always @(posedge i_clk) begin
    if (i_nrst) begin
      assert (!r_cache_we || r_state == WRITE);
      assert (!r_mem_req || r_state == REQ);
      assert (r_cnt <= CNT_W'(NBEATS));
    end
  end
endmodule
